// File: rtl/issue_scoreboard.sv
// Decode issue controller: 32-entry busy scoreboard, RAW/WAW/in-flight-limit stalls.
// o_issue/o_stall combinational; scoreboard, counters and error flag update one cycle later.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [4:0]           i_rs1_raddr,
  input  logic [4:0]           i_rs2_raddr,
  input  logic                 i_rs1_used,
  input  logic                 i_rs2_used,
  input  logic [4:0]           i_rd,
  input  logic                 i_reg_write,
  input  logic                 i_ex_ready,
  input  logic                 i_flush,
  input  logic                 i_wb_en,
  input  logic [4:0]           i_wb_addr,
  output logic                 o_issue,
  output logic                 o_stall,
  output logic [31:0]          o_busy,
  output logic [3:0]           o_inflight,
  output logic [CNT_WIDTH-1:0] o_stall_count,
  output logic                 o_sb_error
);

  localparam logic [3:0] MaxInfl = 4'(MAX_INFLIGHT);

  logic [31:0]          busy_q, busy_d;
  logic [3:0]           inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 sb_err_q, sb_err_d;

  logic [31:0] eff_busy;
  logic [3:0]  inflight_after_wb;
  logic        wb_legal, wb_bad, rd_writes;
  logic        raw, waw, full, stall, issue;

  always_comb begin
    eff_busy = busy_q;
    if (i_wb_en) eff_busy[i_wb_addr] = 1'b0;
    // x0 is never tracked, so it can never look busy
    eff_busy[0] = 1'b0;

    wb_legal  = i_wb_en && (i_wb_addr != 5'd0) && busy_q[i_wb_addr];
    wb_bad    = i_wb_en && (i_wb_addr != 5'd0) && !busy_q[i_wb_addr];
    rd_writes = i_reg_write && (i_rd != 5'd0);

    inflight_after_wb = inflight_q - {3'b000, wb_legal};

    raw  = (i_rs1_used && eff_busy[i_rs1_raddr]) || (i_rs2_used && eff_busy[i_rs2_raddr]);
    waw  = rd_writes && eff_busy[i_rd];
    full = rd_writes && (inflight_after_wb == MaxInfl);

    stall = !i_rst && i_valid && !i_flush && (raw || waw || full || !i_ex_ready);
    issue = !i_rst && i_valid && !i_flush && !stall;

    // Clear-then-set so a same-cycle writeback and reissue of one register leaves it busy
    busy_d = busy_q;
    if (wb_legal) busy_d[i_wb_addr] = 1'b0;
    if (issue && rd_writes) busy_d[i_rd] = 1'b1;

    inflight_d = inflight_after_wb + {3'b000, (issue && rd_writes)};
    sb_err_d   = sb_err_q || wb_bad;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q      <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign o_issue       = issue;
  assign o_stall       = stall;
  assign o_busy        = busy_q;
  assign o_inflight    = inflight_q;
  assign o_stall_count = stall_cnt_q;
  assign o_sb_error    = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized bench for issue_scoreboard: driver feeds a pending-register-set model and queues expectations; monitor compares.
module tb_issue_scoreboard;

  localparam int MAXI = 4;

  logic        i_clk, i_rst, i_valid, i_rs1_used, i_rs2_used, i_reg_write;
  logic        i_ex_ready, i_flush, i_wb_en;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr, i_rd, i_wb_addr;
  logic        o_issue, o_stall, o_sb_error;
  logic [31:0] o_busy, o_stall_count;
  logic [3:0]  o_inflight;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_rs1_raddr(i_rs1_raddr), .i_rs2_raddr(i_rs2_raddr),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd(i_rd), .i_reg_write(i_reg_write), .i_ex_ready(i_ex_ready),
    .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
    .o_issue(o_issue), .o_stall(o_stall), .o_busy(o_busy),
    .o_inflight(o_inflight), .o_stall_count(o_stall_count), .o_sb_error(o_sb_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit       rst, valid, rs1u, rs2u, rw, exr, flush, wben;
    bit [4:0] rs1, rs2, rd, wba;
  } stim_t;

  typedef struct {
    bit          issue, stall, err;
    bit [31:0]   busy;
    int          infl;
    longint      cnt;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference state: set of registers with a pending write, plus counters
  bit     pend[32];
  longint m_cnt = 0;
  bit     m_err = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.exr = 1'b1;
    return s;
  endfunction

  function automatic int pend_count();
    int n = 0;
    for (int r = 1; r < 32; r++) if (pend[r]) n++;
    return n;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   eff[32];
    bit   raw, waw, full, legal, rdw, stl, iss;
    @(posedge i_clk);
    #1;
    i_rst = s.rst; i_valid = s.valid; i_rs1_raddr = s.rs1; i_rs2_raddr = s.rs2;
    i_rs1_used = s.rs1u; i_rs2_used = s.rs2u; i_rd = s.rd; i_reg_write = s.rw;
    i_ex_ready = s.exr; i_flush = s.flush; i_wb_en = s.wben; i_wb_addr = s.wba;

    e.busy = '0;
    for (int r = 0; r < 32; r++) e.busy[r] = pend[r];
    e.infl = pend_count();
    e.cnt  = m_cnt;
    e.err  = m_err;

    if (s.rst) begin
      e.issue = 0; e.stall = 0;
      for (int r = 0; r < 32; r++) pend[r] = 0;
      m_cnt = 0; m_err = 0;
    end else begin
      eff = pend;
      if (s.wben) eff[s.wba] = 0;
      eff[0] = 0;
      rdw   = s.rw && (s.rd != 0);
      legal = s.wben && (s.wba != 0) && pend[s.wba];
      raw   = (s.rs1u && eff[s.rs1]) || (s.rs2u && eff[s.rs2]);
      waw   = rdw && eff[s.rd];
      full  = rdw && ((pend_count() - (legal ? 1 : 0)) == MAXI);
      stl   = s.valid && !s.flush && (raw || waw || full || !s.exr);
      iss   = s.valid && !s.flush && !stl;
      e.issue = iss; e.stall = stl;
      if (s.wben && s.wba != 0) begin
        if (pend[s.wba]) pend[s.wba] = 0;
        else m_err = 1;
      end
      if (iss && rdw) pend[s.rd] = 1;
      if (stl && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: DUT outputs are stable mid-cycle; one expectation per driven cycle
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("issue",       longint'(o_issue),       longint'(e.issue));
      chk("stall",       longint'(o_stall),       longint'(e.stall));
      chk("busy",        longint'(o_busy),        longint'(e.busy));
      chk("inflight",    longint'(o_inflight),    longint'(e.infl));
      chk("stall_count", longint'(o_stall_count), e.cnt);
      chk("sb_error",    longint'(o_sb_error),    longint'(e.err));
    end
  end

  stim_t s;

  initial begin
    for (int r = 0; r < 32; r++) pend[r] = 0;
    i_rst = 1; i_valid = 0; i_rs1_raddr = 0; i_rs2_raddr = 0; i_rs1_used = 0;
    i_rs2_used = 0; i_rd = 0; i_reg_write = 0; i_ex_ready = 1; i_flush = 0;
    i_wb_en = 0; i_wb_addr = 0;
    repeat (2) @(posedge i_clk);

    s = idle(); s.rst = 1; apply(s);
    // addi x5
    s = idle(); s.valid = 1; s.rd = 5; s.rw = 1; apply(s);
    // RAW on x5, then bypassed writeback releases it
    s = idle(); s.valid = 1; s.rs1 = 5; s.rs1u = 1; s.rd = 8; s.rw = 1;
    repeat (3) apply(s);
    s.wben = 1; s.wba = 5; apply(s);
    // WAW on x7, then writeback+reissue same cycle
    s = idle(); s.valid = 1; s.rd = 7; s.rw = 1; apply(s);
    apply(s); apply(s);
    s.wben = 1; s.wba = 7; apply(s);
    // In-flight limit
    s = idle(); s.rst = 1; apply(s);
    for (int r = 1; r <= 4; r++) begin
      s = idle(); s.valid = 1; s.rd = 5'(r); s.rw = 1; apply(s);
    end
    s = idle(); s.valid = 1; s.rd = 6; s.rw = 1; apply(s); apply(s);
    s = idle(); s.valid = 1; s.rs1u = 1; s.rs1 = 0; s.rs2u = 1; s.rs2 = 6; apply(s);
    // Illegal writeback, x0 traffic
    s = idle(); s.wben = 1; s.wba = 9; apply(s);
    s = idle(); s.wben = 1; s.wba = 0; apply(s);
    s = idle(); s.valid = 1; s.rd = 0; s.rw = 1; apply(s);
    apply(idle());
    // Hazard squashed by flush
    s = idle(); s.valid = 1; s.rs1u = 1; s.rs1 = 2; s.rd = 3; s.rw = 1; s.flush = 1; apply(s);
    // Mid-stream reset with busy = 0x1E
    apply(idle());
    s = idle(); s.rst = 1; s.valid = 1; s.rd = 10; s.rw = 1; apply(s);
    apply(idle());

    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.valid = ($urandom_range(0, 9) < 8);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.rs1u  = $urandom_range(0, 1);
      s.rs2u  = $urandom_range(0, 1);
      s.rd    = 5'($urandom_range(0, 7));
      s.rw    = ($urandom_range(0, 9) < 7);
      s.exr   = ($urandom_range(0, 9) < 8);
      s.flush = ($urandom_range(0, 9) == 0);
      s.wben  = ($urandom_range(0, 9) < 4);
      s.wba   = 5'($urandom_range(0, 7));
      apply(s);
    end

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge i_clk);
        waited++;
      end
      @(posedge i_clk);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Decode-stage issue controller for the RV32I pipeline.
- Tracks in-flight register writes in a 32-entry busy scoreboard fed by issue and writeback.
- Stalls decode on RAW/WAW hazards and on an in-flight limit; issues otherwise.
- Sits between decode (register addresses, reg-write control) and the execute-stage handshake; the writeback port mirrors the register-file write port.

Parameters:
MAX_INFLIGHT, 4, max outstanding register-writing instructions (1..15)
CNT_WIDTH, 32, width of stall-cycle performance counter

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  decode holds a valid instruction
i_rs1_raddr  input  5  source 1 address
i_rs2_raddr  input  5  source 2 address
i_rs1_used  input  1  instruction reads rs1
i_rs2_used  input  1  instruction reads rs2
i_rd  input  5  destination address
i_reg_write  input  1  instruction writes rd
i_ex_ready  input  1  execute stage accepts an instruction this cycle
i_flush  input  1  squash the instruction in decode
i_wb_en  input  1  writeback commits this cycle
i_wb_addr  input  5  writeback destination
o_issue  output  1  instruction leaves decode this cycle
o_stall  output  1  decode must hold its instruction
o_busy  output  32  scoreboard; bit n = write to xn pending
o_inflight  output  4  outstanding register-writing instructions
o_stall_count  output  CNT_WIDTH  cycles with o_stall=1
o_sb_error  output  1  sticky; writeback to a non-busy register seen

Behaviour:
- Reset (i_rst=1 at posedge): o_busy=0, o_inflight=0, o_stall_count=0, o_sb_error=0. During reset, o_issue=0 and o_stall=0 regardless of inputs.
- Effective busy: eff_busy = o_busy with bit i_wb_addr cleared when i_wb_en=1. This is a same-cycle writeback bypass and matches the write-through register file.
- Hazards, all combinational, using eff_busy; register x0 is never a hazard:
  - raw: (i_rs1_used and eff_busy[rs1]) or (i_rs2_used and eff_busy[rs2]).
  - waw: i_reg_write and rd!=0 and eff_busy[rd].
  - full: i_reg_write and rd!=0 and inflight_after_wb == MAX_INFLIGHT, where inflight_after_wb = o_inflight minus 1 if a legal wb occurs.
- o_stall = i_valid & ~i_flush & (raw | waw | full | ~i_ex_ready).
- o_issue = i_valid & ~i_flush & ~o_stall.
- Next-state scoreboard update:
  - A legal wb (i_wb_en, i_wb_addr!=0, busy bit set) clears the bit and decrements inflight.
  - A wb with i_wb_addr!=0 and the bit clear sets o_sb_error; busy and inflight are unchanged.
  - A wb to x0 is ignored.
  - Issue with i_reg_write and rd!=0 sets busy[rd] and increments inflight.
  - When wb and issue target the same register in one cycle: clear then set, so the bit ends 1 and inflight is unchanged.
- o_stall_count increments by 1 each cycle o_stall=1 and saturates at all-ones.
- Flush: the decode instruction is dropped (no issue, no stall, no scoreboard change). Writebacks in the same cycle still apply.
- All state-changing outputs are registered with 1-cycle latency. o_issue and o_stall are combinational.
- Invariant: popcount(o_busy) == o_inflight.

Test Plan:
- Reset, then issue `addi x5` (rd=5, valid, ex_ready) -> o_issue=1; next cycle o_busy=0x00000020, o_inflight=1.
- With x5 busy, instr using rs1=5 -> o_stall=1 each cycle and o_stall_count counts. Assert i_wb_en with addr 5 -> o_issue=1 in that same cycle (bypass); next cycle busy[5] is cleared.
- WAW: x7 busy and a new instr writes rd=7 -> stall. Writeback x7 plus issue in the same cycle -> o_busy[7]=1 and o_inflight unchanged.
- MAX_INFLIGHT=4: issue writes to x1..x4, then a 5th writer to x6 -> o_stall=1. A store (i_reg_write=0) with no RAW -> o_issue=1.
- Writeback to x9 while not busy -> o_sb_error=1 and stays 1 until i_rst. Writebacks to x0, and issues with rd=0, never change o_busy or o_inflight.
- Hazard present with i_flush=1 -> o_stall=0 and o_issue=0. i_rst mid-stream with busy=0x1E -> all state 0 the next cycle.
